// File: rtl/load_store_unit.sv
// Load/store unit: sole master of the data_memory port. Converts byte/half/word requests
// into aligned big-endian word accesses. Optional LSU_MISALIGN_TRAP_EN traps misaligned accesses.
module load_store_unit #(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [31:0] addr_p0;
    logic [1:0]  size_p0;
    logic        uns_p0;
    logic [31:0] wdata_p0;
    logic        err_p0;
    logic [31:0] rd_word_p1;
    logic [31:0] rdata_p1;

    logic        accept;
    logic [2:0]  req_bytes;
    logic [32:0] req_end;
    logic        range_err;
    logic        misalign;
    logic        req_err;
    logic [31:0] req_addr_al;

    // Pick the addressed big-endian lane out of a word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        res;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            2'b00:   res = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   res = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed big-endian lane of the old word with right-justified store data.
    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] size, input logic [1:0] off);
        logic [31:0] res;
        res = word;
        if (size == 2'b00) begin
            case (off)
                2'd0:    res[31:24] = wdata[7:0];
                2'd1:    res[23:16] = wdata[7:0];
                2'd2:    res[15:8]  = wdata[7:0];
                default: res[7:0]   = wdata[7:0];
            endcase
        end else if (size == 2'b01) begin
            if (off[1]) res[15:0]  = wdata[15:0];
            else        res[31:16] = wdata[15:0];
        end else begin
            res = wdata;
        end
        return res;
    endfunction

    assign accept = (state == IDLE) && req_valid;

    // 33-bit end address so an access near 0xFFFFFFFF cannot wrap back into range.
    always_comb begin
        case (req_size)
            2'b00:   req_bytes = 3'd1;
            2'b01:   req_bytes = 3'd2;
            default: req_bytes = 3'd4;
        endcase
        req_end   = {1'b0, req_addr} + {30'd0, req_bytes};
        range_err = req_end > 33'(MEM_BYTES);
        misalign  = ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
        req_err     = (req_size == 2'b11) || range_err || misalign;
        req_addr_al = req_addr;
`else
        req_err     = (req_size == 2'b11) || range_err;
        req_addr_al = req_addr;
        if (misalign) begin
            if (req_size == 2'b01) req_addr_al = {req_addr[31:1], 1'b0};
            else                   req_addr_al = {req_addr[31:2], 2'b00};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)              state_nxt = RESP;
                    else if (!req_we)         state_nxt = LOAD;
                    else if (req_size == 2'b10) state_nxt = STORE;
                    else                      state_nxt = RMW_RD;
                end
            end
            LOAD:    state_nxt = RESP;
            STORE:   state_nxt = RESP;
            RMW_RD:  state_nxt = RMW_WR;
            RMW_WR:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: request capture in IDLE; stage p1: memory read data (load result or RMW old word).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_p0    <= '0;
            size_p0    <= '0;
            uns_p0     <= 1'b0;
            wdata_p0   <= '0;
            err_p0     <= 1'b0;
            rd_word_p1 <= '0;
            rdata_p1   <= '0;
        end else begin
            if (accept) begin
                addr_p0  <= req_addr_al;
                size_p0  <= req_size;
                uns_p0   <= req_unsigned;
                wdata_p0 <= req_wdata;
                err_p0   <= req_err;
                rdata_p1 <= '0;
            end
            if (state == LOAD)   rdata_p1   <= load_extend(mem_rd, size_p0, addr_p0[1:0], uns_p0);
            if (state == RMW_RD) rd_word_p1 <= mem_rd;
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = (state == RESP) && err_p0;
    assign resp_rdata = rdata_p1;
    assign mem_a      = {addr_p0[31:2], 2'b00};
    assign mem_we     = (state == STORE) || (state == RMW_WR);

    always_comb begin
        mem_wd = '0;
        if (state == STORE)  mem_wd = wdata_p0;
        if (state == RMW_WR) mem_wd = merge_lane(rd_word_p1, wdata_p0, size_p0, addr_p0[1:0]);
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a 256-byte big-endian memory model.
// Expectations for misaligned accesses follow LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we),
        .mem_rd(mem_rd)
    );

    logic [7:0] mem [0:255];
    logic [7:0] ma;
    assign ma     = mem_a[7:0];
    assign mem_rd = {mem[ma], mem[ma + 8'd1], mem[ma + 8'd2], mem[ma + 8'd3]};

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int we_cnt = 0;
    int resp_cnt = 0;
    int acc_cyc[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            we_cnt <= we_cnt + 1;
            mem[ma]        <= mem_wd[31:24];
            mem[ma + 8'd1] <= mem_wd[23:16];
            mem[ma + 8'd2] <= mem_wd[15:8];
            mem[ma + 8'd3] <= mem_wd[7:0];
        end
        if (resp_valid) resp_cnt <= resp_cnt + 1;
        if (rst_n && req_valid && req_ready) acc_cyc.push_back(cyc);
    end

    logic [31:0] r_data;
    logic        r_err;
    int          r_lat;

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        r_lat = 0;
        do begin
            @(negedge clk);
            r_lat++;
        end while (!resp_valid && r_lat < 10);
        r_data = resp_rdata;
        r_err  = resp_err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp got=%b%b exp=00", resp_valid, resp_err); end
        checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
        checks++; if (mem_we !== 1'b0 || mem_a !== 32'h0 || mem_wd !== 32'h0) begin failures++; $display("FAIL reset_mem got=%b %h %h exp=0 0 0", mem_we, mem_a, mem_wd); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_word();
        do_req(1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
        checks++; if (r_data !== 32'hDEADBEEF) begin failures++; $display("FAIL lw0_data got=%h exp=deadbeef", r_data); end
        checks++; if (r_lat !== 2) begin failures++; $display("FAIL lw0_latency got=%0d exp=2", r_lat); end
        checks++; if (r_err !== 1'b0) begin failures++; $display("FAIL lw0_err got=%b exp=0", r_err); end
    endtask

    task automatic test_load_sub();
        logic [1:0]  sz  [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
        logic        un  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ad  [6] = '{32'd2, 32'd2, 32'd2, 32'd0, 32'd3, 32'd0};
        logic [31:0] ex  [6] = '{32'hFFFFFFBE, 32'h000000BE, 32'hFFFFBEEF, 32'h0000DEAD, 32'hFFFFFFEF, 32'h000000DE};
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, sz[i], un[i], ad[i], 32'd0);
            checks++; if (r_data !== ex[i] || r_err !== 1'b0) begin failures++; $display("FAIL subload_%0d got=%h err=%b exp=%h err=0", i, r_data, r_err, ex[i]); end
        end
    endtask

    task automatic test_store();
        int w0;
        w0 = we_cnt;
        do_req(1'b1, 2'b00, 1'b0, 32'd1, 32'hFFFFFF12);
        checks++; if (r_lat !== 3 || we_cnt - w0 !== 1 || r_data !== 32'h0) begin failures++; $display("FAIL sb1 got lat=%0d we=%0d rdata=%h exp lat=3 we=1 rdata=0", r_lat, we_cnt - w0, r_data); end
        do_req(1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
        checks++; if (r_data !== 32'hDE12BEEF) begin failures++; $display("FAIL sb1_readback got=%h exp=de12beef", r_data); end
        w0 = we_cnt;
        do_req(1'b1, 2'b01, 1'b0, 32'd2, 32'hABCD3456);
        checks++; if (r_lat !== 3 || we_cnt - w0 !== 1) begin failures++; $display("FAIL sh2 got lat=%0d we=%0d exp lat=3 we=1", r_lat, we_cnt - w0); end
        do_req(1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
        checks++; if (r_data !== 32'hDE123456) begin failures++; $display("FAIL sh2_readback got=%h exp=de123456", r_data); end
        w0 = we_cnt;
        do_req(1'b1, 2'b10, 1'b0, 32'd4, 32'hCAFEF00D);
        checks++; if (r_lat !== 2 || we_cnt - w0 !== 1) begin failures++; $display("FAIL sw4 got lat=%0d we=%0d exp lat=2 we=1", r_lat, we_cnt - w0); end
        do_req(1'b0, 2'b10, 1'b0, 32'd4, 32'd0);
        checks++; if (r_data !== 32'hCAFEF00D) begin failures++; $display("FAIL sw4_readback got=%h exp=cafef00d", r_data); end
    endtask

    task automatic test_misalign();
        int w0;
        w0 = we_cnt;
        do_req(1'b0, 2'b10, 1'b0, 32'd2, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (r_err !== 1'b1 || r_data !== 32'h0 || r_lat !== 1) begin failures++; $display("FAIL lw2_trap got err=%b data=%h lat=%0d exp err=1 data=0 lat=1", r_err, r_data, r_lat); end
        do_req(1'b0, 2'b01, 1'b0, 32'd1, 32'd0);
        checks++; if (r_err !== 1'b1 || r_data !== 32'h0) begin failures++; $display("FAIL lh1_trap got err=%b data=%h exp err=1 data=0", r_err, r_data); end
        do_req(1'b1, 2'b01, 1'b0, 32'd1, 32'h0000AAAA);
        checks++; if (r_err !== 1'b1 || we_cnt !== w0) begin failures++; $display("FAIL sh1_trap got err=%b writes=%0d exp err=1 writes=0", r_err, we_cnt - w0); end
`else
        checks++; if (r_err !== 1'b0 || r_data !== 32'hDE123456) begin failures++; $display("FAIL lw2_align got err=%b data=%h exp err=0 data=de123456", r_err, r_data); end
        do_req(1'b0, 2'b01, 1'b0, 32'd1, 32'd0);
        checks++; if (r_err !== 1'b0 || r_data !== 32'hFFFFDE12) begin failures++; $display("FAIL lh1_align got err=%b data=%h exp err=0 data=ffffde12", r_err, r_data); end
        checks++; if (we_cnt !== w0) begin failures++; $display("FAIL misalign_load_writes got=%0d exp=0", we_cnt - w0); end
`endif
    endtask

    task automatic test_errors();
        int w0;
        w0 = we_cnt;
        do_req(1'b0, 2'b10, 1'b0, 32'd254, 32'd0);
        checks++; if (r_err !== 1'b1 || r_data !== 32'h0 || r_lat !== 1) begin failures++; $display("FAIL lw254 got err=%b data=%h lat=%0d exp err=1 data=0 lat=1", r_err, r_data, r_lat); end
        do_req(1'b1, 2'b10, 1'b0, 32'd254, 32'h11223344);
        checks++; if (r_err !== 1'b1 || we_cnt !== w0) begin failures++; $display("FAIL sw254 got err=%b writes=%0d exp err=1 writes=0", r_err, we_cnt - w0); end
        do_req(1'b1, 2'b11, 1'b0, 32'd0, 32'h11223344);
        checks++; if (r_err !== 1'b1 || we_cnt !== w0) begin failures++; $display("FAIL size11 got err=%b writes=%0d exp err=1 writes=0", r_err, we_cnt - w0); end
        do_req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'd0);
        checks++; if (r_err !== 1'b1) begin failures++; $display("FAIL lw_wrap got err=%b exp=1", r_err); end
        do_req(1'b1, 2'b00, 1'b0, 32'd255, 32'h00000077);
        checks++; if (r_err !== 1'b0 || we_cnt - w0 !== 1) begin failures++; $display("FAIL sb255 got err=%b writes=%0d exp err=0 writes=1", r_err, we_cnt - w0); end
        do_req(1'b0, 2'b01, 1'b1, 32'd254, 32'd0);
        checks++; if (r_err !== 1'b0 || r_data !== 32'h00000077) begin failures++; $display("FAIL lhu254 got err=%b data=%h exp err=0 data=00000077", r_err, r_data); end
    endtask

    task automatic test_reset_mid();
        int w0;
        int rc0;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'h00000055; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        w0 = we_cnt; rc0 = resp_cnt;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL midrst_async got we=%b ready=%b exp we=0 ready=1", mem_we, req_ready); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (we_cnt !== w0 || resp_cnt !== rc0) begin failures++; $display("FAIL midrst_quiet got writes=%0d resps=%0d exp 0 0", we_cnt - w0, resp_cnt - rc0); end
        checks++; if (mem[0] !== 8'hDE || req_ready !== 1'b1) begin failures++; $display("FAIL midrst_state got mem0=%h ready=%b exp de 1", mem[0], req_ready); end
        do_req(1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
        checks++; if (r_data !== 32'hDE123456) begin failures++; $display("FAIL midrst_readback got=%h exp=de123456", r_data); end
    endtask

    task automatic test_back_to_back();
        int n0;
        int r0;
        int w0;
        int bad;
        // Loads held valid: accepts every 3 cycles.
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        n0 = acc_cyc.size(); r0 = resp_cnt;
        req_valid = 1'b1;
        repeat (10) @(negedge clk);
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (acc_cyc.size() - n0 !== 4 || resp_cnt - r0 !== 4) begin failures++; $display("FAIL b2b_load got acc=%0d resp=%0d exp 4 4", acc_cyc.size() - n0, resp_cnt - r0); end
        bad = 0;
        for (int i = n0 + 1; i < acc_cyc.size(); i++) if (acc_cyc[i] - acc_cyc[i-1] != 3) bad++;
        checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_load_gap got bad_gaps=%0d exp=0", bad); end
        // Byte stores held valid: accepts every 4 cycles, one write each.
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_addr = 32'd3; req_wdata = 32'h00000056;
        n0 = acc_cyc.size(); r0 = resp_cnt; w0 = we_cnt;
        req_valid = 1'b1;
        repeat (9) @(negedge clk);
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (acc_cyc.size() - n0 !== 3 || resp_cnt - r0 !== 3 || we_cnt - w0 !== 3) begin failures++; $display("FAIL b2b_store got acc=%0d resp=%0d we=%0d exp 3 3 3", acc_cyc.size() - n0, resp_cnt - r0, we_cnt - w0); end
        bad = 0;
        for (int i = n0 + 1; i < acc_cyc.size(); i++) if (acc_cyc[i] - acc_cyc[i-1] != 4) bad++;
        checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_store_gap got bad_gaps=%0d exp=0", bad); end
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'hDE; mem[1] = 8'hAD; mem[2] = 8'hBE; mem[3] = 8'hEF;
        test_reset();
        test_load_word();
        test_load_sub();
        test_store();
        test_misalign();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
